packet_field_sequencer: RTL and testbench

Sequences byte-wise parsing of one packet across the field parsers of the receive path. It detects the start-of-frame byte and steps through HDR_BYTES header bytes, then BODY_BYTES payload+CRC bytes. Per byte, it raises exactly one field enable; the body enable drives the payload/CRC byte-counter FSM's `control` input. It also clears the field parsers at the start of each packet and reports packet completion or abort.

---
 rtl/packet_parser_pkg.sv | 33 +++
 rtl/packet_field_sequencer_if.sv | 42 ++++
 rtl/pkt_gap_timer.sv | 43 ++++
 rtl/packet_field_sequencer.sv | 139 +++++++++++++
 tb/tb_packet_field_sequencer.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/packet_parser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : packet_parser_pkg
// Description : Shared definitions for the receive-path packet parsers.
//               Contains the sequencer state enum, the default start-of-frame
//               delimiter, the default field lengths and small sizing helpers
//               used by the sequencer and the field parser FSMs.
// Revision    : 1.0 - initial release
// ============================================================================
package packet_parser_pkg;

    // Sequencer states: waiting for SOF, walking header, walking payload+CRC.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        BODY   = 2'd2
    } pkt_state_t;

    localparam logic [7:0] c_sof_byte   = 8'hA5;
    localparam int         c_hdr_bytes  = 4;
    localparam int         c_body_bytes = 50;

    function automatic int max_len(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold the values 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/packet_field_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : packet_field_sequencer_if
// Description : Byte stream in / field enables out bundle of the packet field
//               sequencer.
//               master : byte source side (drives data, data_valid)
//               slave  : sequencer side (drives enables, index and pulses)
//               Signals: data[7:0], data_valid, fields_clear, hdr_en,
//               hdr_index, body_en, busy, packet_done, packet_abort.
// Revision    : 1.0 - initial release
// ============================================================================
interface packet_field_sequencer_if
    import packet_parser_pkg::*;
#(
    parameter int HDR_BYTES = c_hdr_bytes
);
    localparam int c_idx_w = $clog2(HDR_BYTES) + 1;

    logic [7:0]         data;
    logic               data_valid;
    logic               fields_clear;
    logic               hdr_en;
    logic [c_idx_w-1:0] hdr_index;
    logic               body_en;
    logic               busy;
    logic               packet_done;
    logic               packet_abort;

    modport master (
        output data, data_valid,
        input  fields_clear, hdr_en, hdr_index, body_en, busy,
               packet_done, packet_abort
    );

    modport slave (
        input  data, data_valid,
        output fields_clear, hdr_en, hdr_index, body_en, busy,
               packet_done, packet_abort
    );

endinterface
`default_nettype wire

// File: rtl/pkt_gap_timer.sv
`default_nettype none
// ============================================================================
// Module      : pkt_gap_timer
// Description : Idle-gap watchdog for an in-progress packet. Counts cycles
//               without a valid byte while active; flags timeout on the cycle
//               in which the gap reaches TIMEOUT_CYCLES.
//               Ports: clock, reset (async, active-low), active (packet in
//               progress), data_valid, timeout (combinational flag).
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_gap_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire  clock,
    input  wire  reset,
    input  wire  active,
    input  wire  data_valid,
    output logic timeout
);
    // The register holds the number of empty cycles already completed, so it
    // never needs to exceed TIMEOUT_CYCLES-1.
    localparam int c_gap_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [c_gap_w-1:0] r_gap;

    // The current empty cycle is the one that brings the gap to the threshold.
    // A valid byte suppresses the flag, so the byte always wins a tie.
    assign timeout = active && !data_valid
                     && (r_gap == c_gap_w'(TIMEOUT_CYCLES - 1));

    // Held at zero outside a packet, so entry from IDLE starts from a clean gap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_gap <= '0;
        end else if (!active || data_valid || timeout) begin
            r_gap <= '0;
        end else begin
            r_gap <= r_gap + c_gap_w'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/packet_field_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : packet_field_sequencer
// Description : Walks one packet byte by byte: waits for SOF_BYTE, then
//               raises hdr_en for HDR_BYTES bytes and body_en for BODY_BYTES
//               bytes. Pulses fields_clear at packet start and packet_done
//               after the last body byte.
//               Optional feature macro PKT_GAP_TIMEOUT_EN: adds an idle-gap
//               watchdog (pkt_gap_timer) that aborts the packet with a
//               packet_abort pulse; without it packet_abort is held at 0.
//               Ports: clock, reset (async, active-low), bus (slave modport
//               of packet_field_sequencer_if).
// Revision    : 1.0 - initial release
// ============================================================================
module packet_field_sequencer
    import packet_parser_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE       = c_sof_byte,
    parameter int         HDR_BYTES      = c_hdr_bytes,
    parameter int         BODY_BYTES     = c_body_bytes,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  wire                     clock,
    input  wire                     reset,
    packet_field_sequencer_if.slave bus
);
    localparam int c_cnt_w = cnt_width(max_len(HDR_BYTES, BODY_BYTES));
    localparam int c_idx_w = $clog2(HDR_BYTES) + 1;

    pkt_state_t         r_state;
    pkt_state_t         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               r_clear;
    logic               r_done;
    logic               r_abort;
    logic               w_clear_nxt;
    logic               w_done_nxt;
    logic               w_abort_nxt;
    logic               w_busy;
    logic               w_timeout;

    assign w_busy = (r_state != IDLE);

`ifdef PKT_GAP_TIMEOUT_EN
    pkt_gap_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clock      (clock),
        .reset      (reset),
        .active     (w_busy),
        .data_valid (bus.data_valid),
        .timeout    (w_timeout)
    );
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
`endif

    // Enables are decoded from the registered state so the field parsers see
    // them in the same cycle as the byte itself.
    assign bus.hdr_en       = (r_state == HEADER) && bus.data_valid;
    assign bus.body_en      = (r_state == BODY) && bus.data_valid;
    assign bus.hdr_index    = bus.hdr_en ? c_idx_w'(r_cnt) : '0;
    assign bus.busy         = w_busy;
    assign bus.fields_clear = r_clear;
    assign bus.packet_done  = r_done;
    assign bus.packet_abort = r_abort;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clear_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        w_abort_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.data_valid && (bus.data == SOF_BYTE)) begin
                    w_state_nxt = HEADER;
                    w_cnt_nxt   = '0;
                    w_clear_nxt = 1'b1;
                end
            end
            HEADER: begin
                if (bus.data_valid) begin
                    if (r_cnt == c_cnt_w'(HDR_BYTES - 1)) begin
                        w_state_nxt = BODY;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_w'(1);
                    end
                end
            end
            BODY: begin
                if (bus.data_valid) begin
                    if (r_cnt == c_cnt_w'(BODY_BYTES - 1)) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_w'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // Timeout only fires on a cycle without a byte, so it never competes
        // with a header/body transition above.
        if (w_timeout) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_abort_nxt = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_clear <= 1'b0;
            r_done  <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_clear <= w_clear_nxt;
            r_done  <= w_done_nxt;
            r_abort <= w_abort_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_packet_field_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_packet_field_sequencer
// Description : Self-checking bench for packet_field_sequencer. A reference
//               model tracks the byte position inside the packet and pushes
//               the expected per-cycle output snapshot into a queue; a monitor
//               pops and compares whenever the DUT asserts any strobe.
//               Honours PKT_GAP_TIMEOUT_EN (TIMEOUT_CYCLES = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_packet_field_sequencer;
    import packet_parser_pkg::*;

    localparam logic [7:0] SOF     = 8'hA5;
    localparam int         HDR     = 4;
    localparam int         BODY    = 50;
    localparam int         TIMEOUT = 8;
    localparam int         IDX_W   = $clog2(HDR) + 1;
`ifdef PKT_GAP_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct packed {
        int               cyc;
        logic             clear;
        logic             hdr;
        logic [IDX_W-1:0] idx;
        logic             body;
        logic             busy;
        logic             done;
        logic             abort;
    } rec_t;

    logic clock;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_fail;
    rec_t exp_q[$];

    // Reference model state: position in packet (-1 = outside a packet).
    int   m_pos;
    int   m_gap;
    bit   m_clear;
    bit   m_done;
    bit   m_abort;

    packet_field_sequencer_if #(.HDR_BYTES(HDR)) bus ();

    packet_field_sequencer #(
        .SOF_BYTE       (SOF),
        .HDR_BYTES      (HDR),
        .BODY_BYTES     (BODY),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {26'd0, bus.fields_clear, bus.hdr_en, bus.body_en, bus.busy,
                   bus.packet_done, bus.packet_abort}, 32'd0);
    endtask

    function automatic void model_reset();
        m_pos   = -1;
        m_gap   = 0;
        m_clear = 0;
        m_done  = 0;
        m_abort = 0;
    endfunction

    // One cycle of the packet rules: emit what is visible this cycle, then
    // advance the position for the byte (or gap) presented.
    function automatic void model_step(input bit v, input logic [7:0] d, input int k);
        rec_t r;
        r       = '0;
        r.cyc   = k;
        r.clear = m_clear;
        r.done  = m_done;
        r.abort = m_abort;
        r.busy  = (m_pos >= 0);
        if (v && m_pos >= 0 && m_pos < HDR) begin
            r.hdr = 1'b1;
            r.idx = IDX_W'(m_pos);
        end
        if (v && m_pos >= HDR) r.body = 1'b1;
        if (r.clear || r.hdr || r.body || r.done || r.abort) exp_q.push_back(r);

        m_clear = 0;
        m_done  = 0;
        m_abort = 0;
        if (m_pos < 0) begin
            if (v && d == SOF) begin
                m_pos   = 0;
                m_gap   = 0;
                m_clear = 1;
            end
        end else if (v) begin
            m_gap = 0;
            m_pos++;
            if (m_pos == HDR + BODY) begin
                m_pos  = -1;
                m_done = 1;
            end
        end else begin
            m_gap++;
            if (TO_EN && m_gap == TIMEOUT) begin
                m_pos   = -1;
                m_abort = 1;
            end
        end
    endfunction

    task automatic drive(input bit v, input logic [7:0] d);
        @(posedge clock);
        #1;
        bus.data_valid = v;
        bus.data       = d;
        model_step(v, d, cyc);
    endtask

    // Non-SOF filler byte for gap cycles and discarded bytes.
    function automatic logic [7:0] rnd_byte();
        logic [7:0] b;
        b = 8'($urandom);
        if (b == SOF) b = 8'h3C;
        return b;
    endfunction

    task automatic send_packet(input int max_gap, input int a5_body_pos);
        logic [7:0] b;
        drive(1'b1, SOF);
        for (int i = 0; i < HDR + BODY; i++) begin
            if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) drive(1'b0, rnd_byte());
            b = rnd_byte();
            if (i == HDR + a5_body_pos) b = SOF;
            drive(1'b1, b);
        end
    endtask

    // Monitor: any asserted strobe must match the next expected snapshot.
    always @(negedge clock) begin
        rec_t a;
        rec_t e;
        if (reset && (bus.fields_clear || bus.hdr_en || bus.body_en ||
                      bus.packet_done || bus.packet_abort)) begin
            a.cyc   = cyc;
            a.clear = bus.fields_clear;
            a.hdr   = bus.hdr_en;
            a.idx   = bus.hdr_index;
            a.body  = bus.body_en;
            a.busy  = bus.busy;
            a.done  = bus.packet_done;
            a.abort = bus.packet_abort;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output cyc=%0d clr=%b hdr=%b idx=%0d body=%b busy=%b done=%b abort=%b, expected none",
                         a.cyc, a.clear, a.hdr, a.idx, a.body, a.busy, a.done, a.abort);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard got cyc=%0d clr=%b hdr=%b idx=%0d body=%b busy=%b done=%b abort=%b, expected cyc=%0d clr=%b hdr=%b idx=%0d body=%b busy=%b done=%b abort=%b",
                             a.cyc, a.clear, a.hdr, a.idx, a.body, a.busy, a.done, a.abort,
                             e.cyc, e.clear, e.hdr, e.idx, e.body, e.busy, e.done, e.abort);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        model_reset();
        reset          = 1'b0;
        bus.data_valid = 1'b0;
        bus.data       = 8'h00;

        // Reset state, including a SOF presented while reset is held.
        repeat (2) begin
            @(negedge clock);
            chk_all_zero("reset_hold");
        end
        bus.data_valid = 1'b1;
        bus.data       = SOF;
        @(negedge clock);
        chk_all_zero("reset_hold_sof");
        bus.data_valid = 1'b0;
        reset          = 1'b1;
        @(negedge clock);
        chk_all_zero("after_reset");

        // Single packet, continuous bytes.
        send_packet(0, -1);
        drive(1'b0, 8'h00);

        // Junk in IDLE, then a normal packet.
        drive(1'b1, 8'h00);
        drive(1'b1, 8'h5A);
        drive(1'b0, 8'h00);
        @(negedge clock);
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);
        send_packet(0, -1);

        // Back-to-back packets: second SOF directly after the last body byte.
        send_packet(0, -1);
        send_packet(0, -1);
        drive(1'b0, 8'h00);

        // SOF value inside the payload is plain data.
        send_packet(0, 10);
        drive(1'b0, 8'h00);

        // Reset after body byte 20 drops the packet.
        drive(1'b1, SOF);
        for (int i = 0; i < HDR + 21; i++) drive(1'b1, rnd_byte());
        @(negedge clock);
        #1;
        reset          = 1'b0;
        bus.data_valid = 1'b0;
        #1;
        chk_all_zero("reset_midpacket");
        chk("reset_queue_empty", exp_q.size(), 32'd0);
        model_reset();
        @(negedge clock);
        chk_all_zero("reset_midpacket_hold");
        reset = 1'b1;
        send_packet(0, -1);
        drive(1'b0, 8'h00);

        // Gap of exactly TIMEOUT cycles in BODY, then the rest of the bytes.
        drive(1'b1, SOF);
        for (int i = 0; i < HDR + 5; i++) drive(1'b1, rnd_byte());
        repeat (TIMEOUT) drive(1'b0, 8'h00);
        for (int i = 0; i < BODY - 5; i++) drive(1'b1, rnd_byte());
        drive(1'b0, 8'h00);

        // Gap of TIMEOUT-1 cycles, then a byte: packet must complete.
        drive(1'b1, SOF);
        for (int i = 0; i < HDR + 5; i++) drive(1'b1, rnd_byte());
        repeat (TIMEOUT - 1) drive(1'b0, 8'h00);
        for (int i = 0; i < BODY - 5; i++) drive(1'b1, rnd_byte());
        drive(1'b0, 8'h00);

        // Long gap in HEADER: unbounded without the watchdog.
        drive(1'b1, SOF);
        drive(1'b1, rnd_byte());
        repeat (300) drive(1'b0, 8'h00);
        for (int i = 0; i < HDR - 1 + BODY; i++) drive(1'b1, rnd_byte());
        drive(1'b0, 8'h00);

        // Randomized traffic: idle junk, random gaps, stray SOF values.
        for (int p = 0; p < 25; p++) begin
            repeat ($urandom_range(3, 0)) drive($urandom_range(1, 0) == 1, rnd_byte());
            send_packet($urandom_range(TIMEOUT + 1, 0) % (TO_EN ? TIMEOUT + 2 : 4),
                        ($urandom_range(1, 0) == 1) ? int'($urandom_range(BODY - 1, 0)) : -1);
        end

        repeat (3) drive(1'b0, 8'h00);
        @(negedge clock);
        chk("final_queue_empty", exp_q.size(), 32'd0);
        chk("final_busy", {31'd0, bus.busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
